// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcodes, ALU and writeback-select
// codes, the decoded bundle carried through the pipeline register, and a
// small helper that turns a load/store size into a byte mask.
package decode_pkg;

    // Base opcodes understood by the decoder
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // funct7 values that select alternate / multiply-divide behaviour
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MD   = 7'b0000001;

    // ALU control codes; bit 3 is the SUB/SRA alternate, bits 2:0 mirror funct3
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    // Writeback source select
    typedef enum logic [2:0] {
        M2R_ALU   = 3'b000,
        M2R_LOAD  = 3'b001,
        M2R_PC4   = 3'b010,
        M2R_IMM   = 3'b011,
        M2R_PCIMM = 3'b100
    } m2r_e;

    // Everything execute needs to know about one instruction
    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu_ctr;
        logic        alu_b_ctr;
        logic [3:0]  bxx;
        logic        jal;
        logic        jalr;
        logic        reg_we;
        logic        mem_we;
        m2r_e        mem2reg;
        logic [2:0]  data_mem_opr;
        logic [3:0]  data_mem_opw;
        logic        md_en;
        logic [2:0]  md_op;
        logic        illegal;
    } decode_bundle_t;

    // Byte-lane mask for a memory access of size funct3[1:0]
    function automatic logic [3:0] mem_mask(input logic [1:0] size);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size)
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            2'b10:   mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-side and execute-side handshake plus the decoded bundle fields.
// The stage itself uses the slave view; the surrounding pipeline (or a bench)
// uses the master view.
interface decode_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu_ctr;
    logic        alu_b_ctr;
    logic [3:0]  bxx;
    logic        jal;
    logic        jalr;
    logic        reg_we;
    logic        mem_we;
    logic [2:0]  mem2reg;
    logic [2:0]  data_mem_opr;
    logic [3:0]  data_mem_opw;
    logic        md_en;
    logic [2:0]  md_op;
    logic        illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, rs1, rs2, rd, imm, alu_ctr,
               alu_b_ctr, bxx, jal, jalr, reg_we, mem_we, mem2reg,
               data_mem_opr, data_mem_opw, md_en, md_op, illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, rs1, rs2, rd, imm, alu_ctr,
               alu_b_ctr, bxx, jal, jalr, reg_we, mem_we, mem2reg,
               data_mem_opr, data_mem_opw, md_en, md_op, illegal
    );
endinterface

// File: rtl/decode_core.sv
// Purely combinational RV32I(+M) decoder: instruction word in, decoded
// bundle out, plus which source registers the format actually reads (used
// by the stage for load-use detection).
module decode_core
    import decode_pkg::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic [31:0]    i_instr,
    output decode_bundle_t o_bundle,
    output logic           o_use_rs1,
    output logic           o_use_rs2
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic        w_legal;
    logic        w_writes_rd;

    assign w_opcode = i_instr[6:0];
    assign w_f3     = i_instr[14:12];
    assign w_f7     = i_instr[31:25];

    assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'b0};
    assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    // Decode by opcode, then suppress every side effect of an illegal encoding
    always_comb begin
        o_bundle     = '0;
        o_use_rs1    = 1'b0;
        o_use_rs2    = 1'b0;
        w_legal      = 1'b0;
        w_writes_rd  = 1'b0;
        o_bundle.rs1 = i_instr[19:15];
        o_bundle.rs2 = i_instr[24:20];
        o_bundle.rd  = i_instr[11:7];
        o_bundle.bxx = {1'b0, w_f3};

        case (w_opcode)
            OPC_LUI: begin
                w_legal            = 1'b1;
                w_writes_rd        = 1'b1;
                o_bundle.imm       = w_imm_u;
                o_bundle.alu_b_ctr = 1'b1;
                o_bundle.mem2reg   = M2R_IMM;
            end
            OPC_AUIPC: begin
                w_legal            = 1'b1;
                w_writes_rd        = 1'b1;
                o_bundle.imm       = w_imm_u;
                o_bundle.alu_b_ctr = 1'b1;
                o_bundle.mem2reg   = M2R_PCIMM;
            end
            OPC_JAL: begin
                w_legal            = 1'b1;
                w_writes_rd        = 1'b1;
                o_bundle.imm       = w_imm_j;
                o_bundle.alu_b_ctr = 1'b1;
                o_bundle.jal       = 1'b1;
                o_bundle.mem2reg   = M2R_PC4;
            end
            OPC_JALR: begin
                w_legal            = (w_f3 == 3'b000);
                w_writes_rd        = 1'b1;
                o_use_rs1          = 1'b1;
                o_bundle.imm       = w_imm_i;
                o_bundle.alu_b_ctr = 1'b1;
                o_bundle.jalr      = 1'b1;
                o_bundle.mem2reg   = M2R_PC4;
            end
            OPC_BRANCH: begin
                w_legal         = (w_f3[2:1] != 2'b01);
                o_use_rs1       = 1'b1;
                o_use_rs2       = 1'b1;
                o_bundle.imm    = w_imm_b;
                o_bundle.bxx[3] = 1'b1;
                // Equality compares by subtraction, ordering by set-less-than
                case (w_f3[2:1])
                    2'b10:   o_bundle.alu_ctr = ALU_SLT;
                    2'b11:   o_bundle.alu_ctr = ALU_SLTU;
                    default: o_bundle.alu_ctr = ALU_SUB;
                endcase
            end
            OPC_LOAD: begin
                w_legal               = w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                w_writes_rd           = 1'b1;
                o_use_rs1             = 1'b1;
                o_bundle.imm          = w_imm_i;
                o_bundle.alu_b_ctr    = 1'b1;
                o_bundle.mem2reg      = M2R_LOAD;
                o_bundle.data_mem_opr = w_f3;
                o_bundle.data_mem_opw = mem_mask(w_f3[1:0]);
            end
            OPC_STORE: begin
                w_legal               = w_f3 inside {3'b000, 3'b001, 3'b010};
                o_use_rs1             = 1'b1;
                o_use_rs2             = 1'b1;
                o_bundle.imm          = w_imm_s;
                o_bundle.alu_b_ctr    = 1'b1;
                o_bundle.mem_we       = 1'b1;
                o_bundle.data_mem_opr = w_f3;
                o_bundle.data_mem_opw = mem_mask(w_f3[1:0]);
            end
            OPC_OPIMM: begin
                w_writes_rd        = 1'b1;
                o_use_rs1          = 1'b1;
                o_bundle.imm       = w_imm_i;
                o_bundle.alu_b_ctr = 1'b1;
                // Shift-immediates carry funct7 in the upper immediate bits
                if (w_f3 == 3'b001) begin
                    w_legal = (w_f7 == F7_BASE);
                end else if (w_f3 == 3'b101) begin
                    w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
                end else begin
                    w_legal = 1'b1;
                end
                o_bundle.alu_ctr = {(w_f3 == 3'b101) && i_instr[30], w_f3};
            end
            OPC_OP: begin
                w_writes_rd = 1'b1;
                o_use_rs1   = 1'b1;
                o_use_rs2   = 1'b1;
                if (w_f7 == F7_MD) begin
                    w_legal        = EN_M;
                    o_bundle.md_en = EN_M;
                    o_bundle.md_op = w_f3;
                end else if (w_f7 == F7_BASE) begin
                    w_legal          = 1'b1;
                    o_bundle.alu_ctr = {1'b0, w_f3};
                end else if (w_f7 == F7_ALT) begin
                    w_legal          = (w_f3 == 3'b000) || (w_f3 == 3'b101);
                    o_bundle.alu_ctr = w_legal ? {1'b1, w_f3} : ALU_ADD;
                end else begin
                    w_legal = 1'b0;
                end
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase

        o_bundle.illegal = !w_legal;
        o_bundle.reg_we  = w_legal && w_writes_rd && (i_instr[11:7] != 5'd0);
        if (!w_legal) begin
            o_bundle.mem_we  = 1'b0;
            o_bundle.jal     = 1'b0;
            o_bundle.jalr    = 1'b0;
            o_bundle.md_en   = 1'b0;
            o_bundle.md_op   = 3'b000;
            o_bundle.bxx[3]  = 1'b0;
            o_bundle.mem2reg = M2R_ALU;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute. Decodes the incoming
// instruction combinationally, holds the result in a valid/ready pipeline
// register, inserts a single bubble on a load-use dependency and counts
// those bubbles in a saturating counter.
module decode_stage
    import decode_pkg::*;
#(
    parameter bit EN_M     = 1'b1,
    parameter bit LOAD_USE = 1'b1,
    parameter int PERF_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    decode_if.slave           bus,
    output logic [PERF_W-1:0] stall_cnt
);

    localparam logic [PERF_W-1:0] CNT_ONE = PERF_W'(1);

    decode_bundle_t    w_dec;
    logic              w_use_rs1;
    logic              w_use_rs2;
    logic              w_held_load;
    logic              w_hazard;
    logic              w_can_load;

    decode_bundle_t    r_bundle;
    logic              r_valid;
    logic [31:0]       r_pc;
    logic [PERF_W-1:0] r_stall_cnt;

    decode_core #(
        .EN_M (EN_M)
    ) u_core (
        .i_instr   (bus.in_instr),
        .o_bundle  (w_dec),
        .o_use_rs1 (w_use_rs1),
        .o_use_rs2 (w_use_rs2)
    );

    // A held load only matters if it really writes a non-zero register
    assign w_held_load = r_valid && (r_bundle.mem2reg == M2R_LOAD) && r_bundle.reg_we
                         && (r_bundle.rd != 5'd0);

    assign w_hazard = LOAD_USE && w_held_load && bus.in_valid &&
                      (((w_dec.rs1 == r_bundle.rd) && w_use_rs1) ||
                       ((w_dec.rs2 == r_bundle.rd) && w_use_rs2));

    assign w_can_load   = !r_valid || bus.out_ready;
    assign bus.in_ready = !flush && !w_hazard && w_can_load;

    // Pipeline register: flush kills, hazard drains to a bubble, otherwise
    // load whenever the slot is empty or being consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_bundle    <= '0;
            r_pc        <= '0;
            r_stall_cnt <= '0;
        end else if (flush) begin
            r_valid  <= 1'b0;
            r_bundle <= '0;
        end else if (w_hazard && bus.out_ready) begin
            r_valid  <= 1'b0;
            r_bundle <= '0;
            if (r_stall_cnt != {PERF_W{1'b1}}) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end else if (w_can_load) begin
            r_valid  <= bus.in_valid;
            r_bundle <= bus.in_valid ? w_dec : '0;
            r_pc     <= bus.in_pc;
        end
    end

    assign stall_cnt        = r_stall_cnt;
    assign bus.out_valid    = r_valid;
    assign bus.out_pc       = r_pc;
    assign bus.rs1          = r_bundle.rs1;
    assign bus.rs2          = r_bundle.rs2;
    assign bus.rd           = r_bundle.rd;
    assign bus.imm          = r_bundle.imm;
    assign bus.alu_ctr      = r_bundle.alu_ctr;
    assign bus.alu_b_ctr    = r_bundle.alu_b_ctr;
    assign bus.bxx          = r_bundle.bxx;
    assign bus.jal          = r_bundle.jal;
    assign bus.jalr         = r_bundle.jalr;
    assign bus.reg_we       = r_bundle.reg_we;
    assign bus.mem_we       = r_bundle.mem_we;
    assign bus.mem2reg      = r_bundle.mem2reg;
    assign bus.data_mem_opr = r_bundle.data_mem_opr;
    assign bus.data_mem_opw = r_bundle.data_mem_opw;
    assign bus.md_en        = r_bundle.md_en;
    assign bus.md_op        = r_bundle.md_op;
    assign bus.illegal      = r_bundle.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a default instance (EN_M=1, LOAD_USE=1)
// and an alternate instance (EN_M=0, LOAD_USE=0) sharing clock and reset.
module tb_decode_stage;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       flush_alt;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt_alt;

    int checks = 0;
    int errors = 0;

    decode_if u_bus ();
    decode_if u_bus_alt ();

    decode_stage #(.EN_M(1'b1), .LOAD_USE(1'b1), .PERF_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (u_bus),
        .stall_cnt (stall_cnt)
    );

    decode_stage #(.EN_M(1'b0), .LOAD_USE(1'b0), .PERF_W(4)) dut_alt (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_alt),
        .bus       (u_bus_alt),
        .stall_cnt (stall_cnt_alt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        u_bus.in_valid = v;
        u_bus.in_instr = instr;
        u_bus.in_pc    = pc;
    endtask

    task automatic drive_alt(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        u_bus_alt.in_valid = v;
        u_bus_alt.in_instr = instr;
        u_bus_alt.in_pc    = pc;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        flush_alt = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        drive_alt(1'b0, 32'h0, 32'h0);
        u_bus.out_ready     = 1'b0;
        u_bus_alt.out_ready = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", u_bus.out_valid, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_reg_we", u_bus.reg_we, 0);
        chk("rst_imm", u_bus.imm, 0);
        chk("rst_in_ready", u_bus.in_ready, 1);
        rst = 1'b0;

        // 1: addi x1,x0,5
        u_bus.out_ready = 1'b1;
        drive(1'b1, 32'h00500093, 32'h100);
        tick();
        $display("txn addi pc=100 out_valid=%0b imm=%0d", u_bus.out_valid, u_bus.imm);
        chk("addi_valid", u_bus.out_valid, 1);
        chk("addi_imm", u_bus.imm, 5);
        chk("addi_alu", u_bus.alu_ctr, 4'b0000);
        chk("addi_alub", u_bus.alu_b_ctr, 1);
        chk("addi_reg_we", u_bus.reg_we, 1);
        chk("addi_rd", u_bus.rd, 1);
        chk("addi_pc", u_bus.out_pc, 32'h100);

        // 2: lw x2,0(x1) then dependent add x3,x2,x2 -> one bubble
        drive(1'b1, 32'h0000A103, 32'h104);
        tick();
        $display("txn lw pc=104 out_valid=%0b mem2reg=%0d", u_bus.out_valid, u_bus.mem2reg);
        chk("lw_valid", u_bus.out_valid, 1);
        chk("lw_mem2reg", u_bus.mem2reg, 3'b001);
        chk("lw_rd", u_bus.rd, 2);
        chk("lw_opw", u_bus.data_mem_opw, 4'b1111);
        chk("lw_opr", u_bus.data_mem_opr, 3'b010);
        drive(1'b1, 32'h002101B3, 32'h108);
        #1;
        chk("hazard_in_ready", u_bus.in_ready, 0);
        tick();
        $display("txn bubble out_valid=%0b stall_cnt=%0d", u_bus.out_valid, stall_cnt);
        chk("bubble_valid", u_bus.out_valid, 0);
        chk("bubble_reg_we", u_bus.reg_we, 0);
        chk("bubble_stall", stall_cnt, 1);
        chk("bubble_in_ready", u_bus.in_ready, 1);
        tick();
        $display("txn add pc=108 out_valid=%0b rd=%0d", u_bus.out_valid, u_bus.rd);
        chk("add_valid", u_bus.out_valid, 1);
        chk("add_pc", u_bus.out_pc, 32'h108);
        chk("add_rd", u_bus.rd, 3);
        chk("add_alub", u_bus.alu_b_ctr, 0);
        chk("add_imm", u_bus.imm, 0);
        chk("add_stall", stall_cnt, 1);

        // 3: mul x3,x1,x2 with EN_M=1
        drive(1'b1, 32'h022081B3, 32'h10C);
        tick();
        $display("txn mul pc=10c md_en=%0b illegal=%0b", u_bus.md_en, u_bus.illegal);
        chk("mul_md_en", u_bus.md_en, 1);
        chk("mul_md_op", u_bus.md_op, 0);
        chk("mul_illegal", u_bus.illegal, 0);
        chk("mul_reg_we", u_bus.reg_we, 1);

        // 4: sub x5,x6,x7 held for three cycles
        drive(1'b1, 32'h407302B3, 32'h110);
        tick();
        $display("txn sub pc=110 alu_ctr=%0h", u_bus.alu_ctr);
        chk("sub_alu", u_bus.alu_ctr, 4'b1000);
        chk("sub_rd", u_bus.rd, 5);
        u_bus.out_ready = 1'b0;
        drive(1'b1, 32'h00500093, 32'h114);
        #1;
        chk("hold_in_ready", u_bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            $display("txn hold cycle=%0d out_pc=%h", i, u_bus.out_pc);
            chk("hold_pc", u_bus.out_pc, 32'h110);
            chk("hold_valid", u_bus.out_valid, 1);
            chk("hold_alu", u_bus.alu_ctr, 4'b1000);
        end
        u_bus.out_ready = 1'b1;
        #1;
        chk("release_in_ready", u_bus.in_ready, 1);
        tick();
        $display("txn addi pc=114 out_pc=%h", u_bus.out_pc);
        chk("release_pc", u_bus.out_pc, 32'h114);
        chk("release_imm", u_bus.imm, 5);

        // beq x1,x2,+8
        drive(1'b1, 32'h00208463, 32'h118);
        tick();
        $display("txn beq pc=118 bxx=%h imm=%0d", u_bus.bxx, u_bus.imm);
        chk("beq_bxx", u_bus.bxx, 4'b1000);
        chk("beq_alu", u_bus.alu_ctr, 4'b1000);
        chk("beq_imm", u_bus.imm, 8);
        chk("beq_reg_we", u_bus.reg_we, 0);
        chk("beq_alub", u_bus.alu_b_ctr, 0);

        // jal x1,-4
        drive(1'b1, 32'hFFDFF0EF, 32'h11C);
        tick();
        $display("txn jal pc=11c imm=%h", u_bus.imm);
        chk("jal_jal", u_bus.jal, 1);
        chk("jal_imm", u_bus.imm, 32'hFFFFFFFC);
        chk("jal_mem2reg", u_bus.mem2reg, 3'b010);
        chk("jal_reg_we", u_bus.reg_we, 1);

        // unsupported opcode
        drive(1'b1, 32'hFFFFFFFF, 32'h120);
        tick();
        $display("txn illegal pc=120 illegal=%0b", u_bus.illegal);
        chk("ill_valid", u_bus.out_valid, 1);
        chk("ill_illegal", u_bus.illegal, 1);
        chk("ill_reg_we", u_bus.reg_we, 0);
        chk("ill_mem_we", u_bus.mem_we, 0);

        // 5: flush during a load-use hazard cycle
        drive(1'b1, 32'h0000A103, 32'h124);
        tick();
        drive(1'b1, 32'h002101B3, 32'h128);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", u_bus.in_ready, 0);
        tick();
        $display("txn flush out_valid=%0b stall_cnt=%0d", u_bus.out_valid, stall_cnt);
        chk("flush_valid", u_bus.out_valid, 0);
        chk("flush_stall", stall_cnt, 1);
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("flush_dropped", u_bus.out_valid, 0);

        // 6: asynchronous reset mid-stream
        drive(1'b1, 32'h00500093, 32'h12C);
        tick();
        chk("pre_rst_valid", u_bus.out_valid, 1);
        drive(1'b0, 32'h0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        $display("txn async_rst out_valid=%0b stall_cnt=%0d", u_bus.out_valid, stall_cnt);
        chk("arst_valid", u_bus.out_valid, 0);
        chk("arst_stall", stall_cnt, 0);
        tick();
        rst = 1'b0;
        drive(1'b1, 32'h00000013, 32'h130);
        tick();
        $display("txn nop pc=130 reg_we=%0b", u_bus.reg_we);
        chk("nop_valid", u_bus.out_valid, 1);
        chk("nop_reg_we", u_bus.reg_we, 0);
        chk("nop_illegal", u_bus.illegal, 0);
        drive(1'b0, 32'h0, 32'h0);

        // Alternate instance: no load-use bubble, no RV32M
        drive_alt(1'b1, 32'h0000A103, 32'h200);
        tick();
        drive_alt(1'b1, 32'h002101B3, 32'h204);
        #1;
        chk("alt_in_ready", u_bus_alt.in_ready, 1);
        tick();
        $display("txn alt add pc=%h stall_cnt=%0d", u_bus_alt.out_pc, stall_cnt_alt);
        chk("alt_add_valid", u_bus_alt.out_valid, 1);
        chk("alt_add_pc", u_bus_alt.out_pc, 32'h204);
        chk("alt_stall", stall_cnt_alt, 0);
        drive_alt(1'b1, 32'h022081B3, 32'h208);
        tick();
        $display("txn alt mul illegal=%0b", u_bus_alt.illegal);
        chk("alt_mul_illegal", u_bus_alt.illegal, 1);
        chk("alt_mul_reg_we", u_bus_alt.reg_we, 0);
        chk("alt_mul_md_en", u_bus_alt.md_en, 0);
        drive_alt(1'b0, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
